vga_scan_gen: RTL and testbench
===============================

// Module: vga_scan_gen
// PURPOSE
//  Raster timing generator for the 640x480@60 display path. It produces the
//  scan_x/scan_y pixel coordinates consumed by every shape-draw stage
//  (cross, circle, square, grid), plus hsync, vsync and the video_on mask.
//  It sits upstream of all draw modules and of the RGB output register.
//  A single system clock is used; the pixel rate is set by a clock-enable divider.
// PARAMETERS
//  CLK_DIV   4    sys clocks per pixel (100 MHz -> 25 MHz); >=2
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//  SYNC_POL  0    sync active level (0 = active-low)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  pix_tick     out  1   one-clk pulse per pixel period (counter advance)
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  video_on     out  1   1 while (h,v) is inside the active area
//  scan_x       out  10  horizontal position 0..H_TOTAL-1
//  scan_y       out  9   vertical position 0..V_ACTIVE-1; 9'h1FF in vblank
//  line_start   out  1   one-clk pulse on the first clk showing scan_x==0
//  frame_start  out  1   one-clk pulse on the first clk showing (0,0)
// BEHAVIOUR
//  - div counter: 0..CLK_DIV-1, wraps. pix_tick=1 when div==CLK_DIV-1.
//  - h_cnt/v_cnt are 10 bits internally. On pix_tick: h_cnt++. At H_TOTAL-1,
//    h_cnt wraps to 0 and v_cnt++. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
//  - All outputs except pix_tick are registered decodes of h_cnt/v_cnt.
//    They are mutually aligned and lag the counters by exactly 1 clk.
//  - hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
//    vsync is active for v in [490,492).
//  - video_on = (h<H_ACTIVE)&&(v<V_ACTIVE). scan_x = h_cnt. scan_y = v_cnt[8:0]
//    when v<V_ACTIVE, else 9'h1FF.
//  - line_start/frame_start are high for exactly one clk, not one pixel period.
//  - Reset (any cycle, including mid-line or mid-sync): div=0, h=0, v=0.
//    Registered outputs during reset: hsync=vsync=~SYNC_POL (inactive),
//    video_on=0, scan_x=0, scan_y=0, line_start=frame_start=0, pix_tick=0.
//  - First clk after rst falls: outputs show (0,0), video_on=1, and
//    line_start=frame_start=1. First pix_tick occurs at clk CLK_DIV-1 after release.
//  - Sync pulses must never be truncated except by reset.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - vga_pkg: H_*/V_* defaults, H_TOTAL/V_TOTAL, coordinate widths
//    (X_W=10, Y_W=9). These constants are shared with the draw modules.
//  - Sub-module clk_en_div (CLK_DIV): produces pix_tick. It is reused by the
//    game-logic debounce.
//  - Body: h/v counters, then a decode register stage.
// TESTING
//  1 rst held 3 clks, released -> next clk: scan_x=0, scan_y=0, video_on=1,
//    frame_start=1; pix_tick first high 3 clks after release.
//  2 Run one line -> scan_x 0..799 with each value held 4 clks;
//    hsync low for exactly 96*4=384 clks, starting at scan_x=656.
//  3 Run one frame -> 525 line_start pulses, 1 frame_start pulse;
//    vsync low for 2*800*4 clks; scan_y=9'h1FF during lines 480..524.
//  4 Wrap check -> after (799,524) the next pixel is (0,0), with frame_start=1
//    and no extra or missing line.
//  5 Assert rst at scan_x=700 (during hsync) -> next clk: hsync inactive and
//    all outputs at reset values; after release, timing restarts as in test 1.
//  6 Over 3 full frames, count clocks with video_on=1 -> 640*480*4 per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// Raster timing constants and decode record shared by the scan generator and draw stages.
// Compile-time only: no latency, no flow control.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 10;

  // One registered decode of the raster position; every field changes together.
  typedef struct packed {
    logic           hsync;
    logic           vsync;
    logic           video_on;
    logic           line_start;
    logic           frame_start;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } scan_t;

  function automatic logic in_span(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-clk o_tick every CLK_DIV clocks, first tick CLK_DIV-1 clks after reset.
// Tick is a decode of the counter register (no input-to-output path); free-running, no backpressure.
module clk_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int            DW   = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (r_div == LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_tick = (r_div == LAST);

endmodule

// File: rtl/vga_scan_gen.sv
// Raster generator: h/v counters advanced by pix_tick, then one decode register stage for coords/syncs/masks.
// Outputs lag the counters by 1 clk (pix_tick is immediate); free-running, no backpressure.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  output logic           o_pix_tick,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_video_on,
  output logic [X_W-1:0] o_scan_x,
  output logic [Y_W-1:0] o_scan_y,
  output logic           o_line_start,
  output logic           o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             w_pix_tick;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_pix_first;
  scan_t            w_dec;
  scan_t            r_dec;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_pix_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Marks the first clk a new counter value is visible, so start pulses last one clk, not one pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pix_first <= 1'b1;
    end else begin
      r_pix_first <= w_pix_tick;
    end
  end

  always_comb begin
    w_dec             = '0;
    w_dec.hsync       = in_span(r_h_cnt, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
    w_dec.vsync       = in_span(r_v_cnt, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
    w_dec.video_on    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_dec.x           = r_h_cnt;
    w_dec.y           = (r_v_cnt < V_ACT) ? r_v_cnt[Y_W-1:0] : '1;
    w_dec.line_start  = r_pix_first && (r_h_cnt == '0);
    w_dec.frame_start = r_pix_first && (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dec       <= '0;
      r_dec.hsync <= ~SYNC_POL;
      r_dec.vsync <= ~SYNC_POL;
    end else begin
      r_dec <= w_dec;
    end
  end

  assign o_pix_tick    = w_pix_tick;
  assign o_hsync       = r_dec.hsync;
  assign o_vsync       = r_dec.vsync;
  assign o_video_on    = r_dec.video_on;
  assign o_scan_x      = r_dec.x;
  assign o_scan_y      = r_dec.y;
  assign o_line_start  = r_dec.line_start;
  assign o_frame_start = r_dec.frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench: full-size instance for line-level timing and reset, shrunken-raster instance for frame-level timing.
module tb_vga_scan_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;

  always #5 clk = ~clk;

  logic       d_pt, d_hs, d_vs, d_vo, d_ls, d_fs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_pt, s_hs, s_vs, s_vo, s_ls, s_fs;
  logic [9:0] s_x;
  logic [8:0] s_y;

  vga_scan_gen u_dut (
    .i_clk(clk), .i_rst(rst), .o_pix_tick(d_pt), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_video_on(d_vo), .o_scan_x(d_x), .o_scan_y(d_y),
    .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  // 16 x 12 raster, 4 clk per pixel: 64 clk per line, 768 clk per frame.
  vga_scan_gen #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) u_small (
    .i_clk(clk), .i_rst(rst_s), .o_pix_tick(s_pt), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_video_on(s_vo), .o_scan_x(s_x), .o_scan_y(s_y),
    .o_line_start(s_ls), .o_frame_start(s_fs)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int k;
    int x;
    int y;
    bit vo, hs, vs, ls, fs, pt;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dpack();
    return {7'd0, d_x, d_y, d_vo, d_hs, d_vs, d_ls, d_fs, d_pt};
  endfunction

  function automatic logic [31:0] spack();
    return {7'd0, s_x, s_y, s_vo, s_hs, s_vs, s_ls, s_fs, s_pt};
  endfunction

  function automatic logic [31:0] vpack(input vec_t v);
    return {7'd0, 10'(v.x), 9'(v.y), v.vo, v.hs, v.vs, v.ls, v.fs, v.pt};
  endfunction

  initial begin
    vec_t tbl[14];
    vec_t rst_vec;
    int   k_now;
    int   cnt;
    int   x_err, hs_low, hs_first, ls_cnt, first_pt;
    int   ls_c[3], fs_c[3], vs_c[3], vo_c[3];
    int   y_err, ls_pos_err, fs_pos_err, wrap_ok;
    logic [9:0] prev_x;
    logic [8:0] prev_y;

    //            k     x    y  vo hs vs ls fs pt
    tbl[0]  = '{   1,   0,   0, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{   2,   0,   0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{   3,   0,   0, 1, 1, 1, 0, 0, 1};
    tbl[3]  = '{   4,   0,   0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{   5,   1,   0, 1, 1, 1, 0, 0, 0};
    tbl[5]  = '{2557, 639,   0, 1, 1, 1, 0, 0, 0};
    tbl[6]  = '{2561, 640,   0, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{2624, 655,   0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{2625, 656,   0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{3008, 751,   0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{3009, 752,   0, 0, 1, 1, 0, 0, 0};
    tbl[11] = '{3199, 799,   0, 0, 1, 1, 0, 0, 1};
    tbl[12] = '{3201,   0,   1, 1, 1, 1, 1, 0, 0};
    tbl[13] = '{3202,   0,   1, 1, 1, 1, 0, 0, 0};
    rst_vec = '{0, 0, 0, 0, 1, 1, 0, 0, 0};

    // Reset held 3 clks, then the table walks line 0 into line 1.
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_state", dpack(), vpack(rst_vec));
    rst = 1'b0;
    k_now = 0;
    for (int i = 0; i < 14; i++) begin
      while (k_now < tbl[i].k) begin
        tick();
        k_now++;
      end
      chk($sformatf("vec%0d_k%0d", i, tbl[i].k), dpack(), vpack(tbl[i]));
    end

    // One complete line from a line_start pulse.
    cnt = 0;
    while (d_ls !== 1'b1 && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("line_start_wait", 32'(d_ls), 32'd1);
    x_err = 0; hs_low = 0; hs_first = -1; ls_cnt = 0;
    for (int i = 0; i < 3200; i++) begin
      if (d_x !== 10'(i / 4)) x_err++;
      if (d_hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
      if (d_ls === 1'b1) ls_cnt++;
      tick();
    end
    chk("line_x_sequence_errors", 32'(x_err), 32'd0);
    chk("line_hsync_low_clks", 32'(hs_low), 32'd384);
    chk("line_hsync_first_x", 32'(hs_first), 32'd656);
    chk("line_start_pulses", 32'(ls_cnt), 32'd1);
    chk("next_line_start", {30'd0, d_ls, 1'b0} | 32'(d_x), 32'd2);

    // Reset mid-hsync at scan_x = 700.
    cnt = 0;
    while (d_x !== 10'd700 && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("reach_x700", 32'(d_x), 32'd700);
    chk("hsync_active_at_x700", 32'(d_hs), 32'd0);
    rst = 1'b1;
    tick();
    chk("reset_mid_hsync", dpack(), vpack(rst_vec));
    tick();
    tick();
    chk("reset_held", dpack(), vpack(rst_vec));
    rst = 1'b0;
    tick();
    chk("restart_k1", dpack(), vpack(tbl[0]));
    first_pt = (d_pt === 1'b1) ? 1 : 0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (first_pt == 0 && d_pt === 1'b1) first_pt = k;
    end
    chk("restart_first_pix_tick", 32'(first_pt), 32'd3);

    // Three frames on the small raster.
    rst_s = 1'b1;
    repeat (3) tick();
    chk("small_reset_state", spack(), vpack(rst_vec));
    rst_s = 1'b0;
    for (int f = 0; f < 3; f++) begin
      ls_c[f] = 0; fs_c[f] = 0; vs_c[f] = 0; vo_c[f] = 0;
    end
    y_err = 0; ls_pos_err = 0; fs_pos_err = 0; wrap_ok = 0;
    prev_x = '0; prev_y = '0;
    for (int k = 1; k <= 2304; k++) begin
      int f;
      int lin;
      tick();
      f   = (k - 1) / 768;
      lin = ((k - 1) % 768) / 64;
      if (s_ls === 1'b1) ls_c[f]++;
      if (s_fs === 1'b1) fs_c[f]++;
      if (s_vs === 1'b0) vs_c[f]++;
      if (s_vo === 1'b1) vo_c[f]++;
      if (s_y !== ((lin < 6) ? 9'(lin) : 9'h1FF)) y_err++;
      if (s_ls !== (((k - 1) % 64) == 0)) ls_pos_err++;
      if (s_fs !== (((k - 1) % 768) == 0)) fs_pos_err++;
      if (k > 1 && s_fs === 1'b1 && s_x === 10'd0 && s_y === 9'd0 &&
          prev_x === 10'd15 && prev_y === 9'h1FF) wrap_ok++;
      prev_x = s_x;
      prev_y = s_y;
    end
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("frame%0d_line_starts", f), 32'(ls_c[f]), 32'd12);
      chk($sformatf("frame%0d_frame_starts", f), 32'(fs_c[f]), 32'd1);
      chk($sformatf("frame%0d_vsync_low_clks", f), 32'(vs_c[f]), 32'd128);
      chk($sformatf("frame%0d_video_on_clks", f), 32'(vo_c[f]), 32'd192);
    end
    chk("frame_scan_y_errors", 32'(y_err), 32'd0);
    chk("line_start_position_errors", 32'(ls_pos_err), 32'd0);
    chk("frame_start_position_errors", 32'(fs_pos_err), 32'd0);
    chk("frame_wraps_to_origin", 32'(wrap_ok), 32'd2);
    tick();
    chk("frame4_start", {29'd0, s_fs, s_ls, s_vo} | {3'd0, s_x, s_y, 10'd0}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
